// File: rtl/dsp_chain_pkg.sv
// Shared constants and prefetch-state type for the DSP chain prefetch controller.
package dsp_chain_pkg;

  localparam int NUM_TAPS  = 4;
  localparam int DATA_W    = 16;
  localparam int CHAIN_LAT = 6;

  typedef enum logic [1:0] {
    PF_EMPTY,
    PF_FILLING,
    PF_FULL
  } pf_state_t;

  function automatic pf_state_t pf_state_of(input logic [2:0] cnt);
    if (cnt == 3'd0)      return PF_EMPTY;
    else if (cnt >= 3'd4) return PF_FULL;
    else                  return PF_FILLING;
  endfunction

endpackage

// File: rtl/dsp_valid_pipe.sv
// Fixed-depth valid-tag delay line matching the DSP chain's b-to-p latency.
module dsp_valid_pipe
  import dsp_chain_pkg::*;
#(
  parameter int DEPTH = CHAIN_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] tags;

  // NOTE: this pipe is reset, unlike a data pipe, because a stale tag would
  // assert p_valid for a sample that no longer exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags <= '0;
    end else if (clr) begin
      tags <= '0;
    end else begin
      tags <= {tags[DEPTH-2:0], din};
    end
  end

  assign dout = tags[DEPTH-1];

endmodule

// File: rtl/dsp_chain_prefetch_ctrl.sv
// Prefetch/commit controller for a 4-tap DSP cascade; optional flush input
// is enabled by defining DSP_CHAIN_CTRL_FLUSH_EN.
module dsp_chain_prefetch_ctrl #(
  parameter int NUM_TAPS  = dsp_chain_pkg::NUM_TAPS,
  parameter int DATA_W    = dsp_chain_pkg::DATA_W,
  parameter int RUN_W     = 16,
  parameter int CHAIN_LAT = dsp_chain_pkg::CHAIN_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef DSP_CHAIN_CTRL_FLUSH_EN
  input  logic                flush,
`endif
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [RUN_W-1:0]    run_len,
  input  logic                b_valid,
  output logic                b_ready,
  output logic [DATA_W-1:0]   a_out,
  output logic [NUM_TAPS-1:0] ena,
  output logic [NUM_TAPS-1:0] ena_d,
  output logic                p_valid,
  output logic                run_done,
  output logic                busy
);
  import dsp_chain_pkg::*;

  logic [2:0]       fill_cnt, fill_next;
  pf_state_t        pf_state, pf_next;
  logic [RUN_W-1:0] run_cnt, run_next;
  logic             busy_next;
  logic             alive;
  logic             clr, hs, consume, last, commit;

`ifdef DSP_CHAIN_CTRL_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  // The chain's A cascade shifts on every accepted beat, so A is a pass-through.
  assign a_out   = s_data;
  // A commit only happens when FULL, so gating on FULL covers it and keeps
  // b_valid out of the s_ready path.
  assign s_ready = alive && (pf_state != PF_FULL);
  assign b_ready = busy;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no branch can
    // leave one unassigned and infer a latch.
    fill_next = fill_cnt;
    run_next  = run_cnt;
    busy_next = busy;
    ena       = '0;
    ena_d     = '0;
    run_done  = 1'b0;
    hs        = s_valid && s_ready;
    consume   = b_valid && busy;
    last      = consume && (run_cnt == RUN_W'(1));
    commit    = (pf_state == PF_FULL) && (!busy || last);

    if (clr) begin
      fill_next = '0;
      run_next  = '0;
      busy_next = 1'b0;
    end else begin
      if (hs) begin
        ena       = '1;
        fill_next = fill_cnt + 3'd1;
      end
      if (consume) run_next = run_cnt - RUN_W'(1);
      if (last) begin
        run_done  = 1'b1;
        busy_next = 1'b0;
      end
      // A commit on the last-sample cycle overrides the busy clear: no bubble.
      if (commit) begin
        ena_d     = '1;
        fill_next = '0;
        run_next  = run_len;
        busy_next = (run_len != '0);
      end
    end
    pf_next = pf_state_of(fill_next);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive    <= 1'b0;
      fill_cnt <= '0;
      pf_state <= PF_EMPTY;
      run_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      alive    <= 1'b1;
      fill_cnt <= fill_next;
      pf_state <= pf_next;
      run_cnt  <= run_next;
      busy     <= busy_next;
    end
  end

  dsp_valid_pipe #(.DEPTH(CHAIN_LAT)) u_valid_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .din   (consume),
    .dout  (p_valid)
  );

endmodule

// File: tb/tb_dsp_chain_prefetch_ctrl.sv
// Directed bench for dsp_chain_prefetch_ctrl; flush scenario runs when
// DSP_CHAIN_CTRL_FLUSH_EN is defined.
module tb_dsp_chain_prefetch_ctrl;

  localparam int NUM_TAPS = 4;
  localparam int DATA_W   = 16;
  localparam int RUN_W    = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush;
  logic                s_valid;
  logic                s_ready;
  logic [DATA_W-1:0]   s_data;
  logic [RUN_W-1:0]    run_len;
  logic                b_valid;
  logic                b_ready;
  logic [DATA_W-1:0]   a_out;
  logic [NUM_TAPS-1:0] ena;
  logic [NUM_TAPS-1:0] ena_d;
  logic                p_valid;
  logic                run_done;
  logic                busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dsp_chain_prefetch_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef DSP_CHAIN_CTRL_FLUSH_EN
    .flush    (flush),
`endif
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .run_len  (run_len),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_out    (a_out),
    .ena      (ena),
    .ena_d    (ena_d),
    .p_valid  (p_valid),
    .run_done (run_done),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] mask(input bit c);
    return c ? 4'hF : 4'h0;
  endfunction

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input bit e_ena, input bit e_rdy, input bit e_enad,
                           input bit e_busy, input bit e_done, input bit e_pv);
    check({tag, ".ena"},      ena,      mask(e_ena));
    check({tag, ".s_ready"},  s_ready,  e_rdy);
    check({tag, ".ena_d"},    ena_d,    mask(e_enad));
    check({tag, ".busy"},     busy,     e_busy);
    check({tag, ".b_ready"},  b_ready,  e_busy);
    check({tag, ".run_done"}, run_done, e_done);
    check({tag, ".p_valid"},  p_valid,  e_pv);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0;
    run_len = '0; b_valid = 1'b0;

    // Reset state
    #12;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    #10 rst_n = 1'b1;
    next_cycle();
    #2 check("post_reset.s_ready", s_ready, 1'b1);
    next_cycle();

    // Basic: four beats, run of 3 with b_valid held from the commit cycle
    for (int k = 0; k <= 14; k++) begin
      s_valid = (k <= 3);
      s_data  = DATA_W'(k + 1);
      run_len = 16'd3;
      b_valid = (k >= 4);
      #2;
      if (k <= 3) check("basic.a_out", a_out, DATA_W'(k + 1));
      check_all($sformatf("basic%0d", k), k <= 3, k != 4, k == 4,
                k >= 5 && k <= 7, k == 7, k >= 11 && k <= 13);
      next_cycle();
    end
    s_valid = 1'b0; b_valid = 1'b0;

    // Back-to-back: second set prefetched during a run of 8, stall while FULL,
    // commit coincides with the 8th sample, then a run of 2
    for (int j = 0; j <= 21; j++) begin
      s_valid = (j <= 3) || (j >= 5 && j <= 11);
      s_data  = DATA_W'(16'h0010 + j);
      run_len = (j < 12) ? 16'd8 : 16'd2;
      b_valid = (j >= 4);
      #2;
      check_all($sformatf("b2b%0d", j), (j <= 3) || (j >= 5 && j <= 8),
                !(j == 4 || (j >= 9 && j <= 12)), j == 4 || j == 12,
                j >= 5 && j <= 14, j == 12 || j == 14, j >= 11 && j <= 20);
      next_cycle();
    end
    s_valid = 1'b0; b_valid = 1'b0;

    // Zero run: run_len=0 commit leaves busy low, next full set commits at once;
    // b_valid while idle must not produce tags
    for (int z = 0; z <= 18; z++) begin
      s_valid = (z <= 3) || (z >= 5 && z <= 8);
      s_data  = DATA_W'(16'h0100 + z);
      run_len = (z < 9) ? 16'd0 : 16'd2;
      b_valid = 1'b1;
      #2;
      check_all($sformatf("zero%0d", z), (z <= 3) || (z >= 5 && z <= 8),
                z != 4 && z != 9, z == 4 || z == 9,
                z == 10 || z == 11, z == 11, z == 16 || z == 17);
      next_cycle();
    end
    s_valid = 1'b0; b_valid = 1'b0;

    // Reset mid-run: run_cnt=5 with three tags in flight
    for (int r = 0; r <= 7; r++) begin
      s_valid = (r <= 3);
      s_data  = DATA_W'(16'h0200 + r);
      run_len = 16'd8;
      b_valid = (r >= 4);
      #2;
      check($sformatf("rst_run%0d.busy", r), busy, r >= 5);
      next_cycle();
    end
    s_valid = 1'b1;
    #2 check("rst_pre.busy", busy, 1'b1);
    rst_n = 1'b0;
    #1 check_all("rst_async", 0, 0, 0, 0, 0, 0);
    s_valid = 1'b0;
    next_cycle();
    next_cycle();
    #3 rst_n = 1'b1;
    for (int q = 0; q < 12; q++) begin
      next_cycle();
      #2;
      check($sformatf("rst_after%0d.p_valid", q), p_valid, 1'b0);
      check($sformatf("rst_after%0d.busy", q), busy, 1'b0);
    end
    b_valid = 1'b0;
    next_cycle();

`ifdef DSP_CHAIN_CTRL_FLUSH_EN
    // Flush during FILLING (fill_cnt=2): four fresh beats needed before commit
    run_len = 16'd0;
    for (int f = 0; f <= 8; f++) begin
      s_valid = (f <= 2) || (f >= 3 && f <= 5) || (f == 7);
      s_data  = DATA_W'(16'h0300 + f);
      flush   = (f == 2);
      #2;
      check($sformatf("flush%0d.ena", f), ena,
            mask((f <= 1) || (f >= 3 && f <= 5) || (f == 7)));
      check($sformatf("flush%0d.ena_d", f), ena_d, mask(f == 8));
      check($sformatf("flush%0d.s_ready", f), s_ready, f != 8);
      next_cycle();
    end
    s_valid = 1'b0; flush = 1'b0;
`endif

    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
